dot_arbiter: RTL

- Shares one dot-product engine between NREQ requesters, e.g. the estimation FSM, the weight-update FSM and the decorrelation FSM.
- Arbitration is round-robin. The block latches the winner's operand vectors and drives the engine's start/reset handshake.
- It returns the result to the winner with a one-hot done pulse.
- A watchdog aborts any transaction whose engine never reports done.

---
 rtl/dot_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dot_arbiter.sv
// Round-robin arbiter that shares one dot-product engine among NREQ requesters. It latches the
// winner's operands, sequences the engine reset/start handshake and aborts hung transactions.
module dot_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned EXT_DIM    = 4,
    parameter int unsigned NREQ       = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NREQ-1:0]                    req,
    input  logic [NREQ*DATA_WIDTH*EXT_DIM-1:0] a_in,
    input  logic [NREQ*DATA_WIDTH*EXT_DIM-1:0] b_in,
    output logic [NREQ-1:0]                    grant,
    output logic [NREQ-1:0]                    done,
    output logic [NREQ-1:0]                    err,
    output logic signed [DATA_WIDTH-1:0]       result,
    output logic                               busy,
    output logic [DATA_WIDTH*EXT_DIM-1:0]      vector_a,
    output logic [DATA_WIDTH*EXT_DIM-1:0]      vector_b,
    output logic                               start_dot_product,
    output logic                               rstn_dot,
    input  logic                               dot_product_done,
    input  logic signed [DATA_WIDTH-1:0]       dot_product_result
);

    localparam int unsigned VEC_W = DATA_WIDTH * EXT_DIM;
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StResp
    } state_e;

    state_e           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [TMR_W-1:0] timer;

    logic [VEC_W-1:0] a_slice [NREQ];
    logic [VEC_W-1:0] b_slice [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_slice
        assign a_slice[k] = a_in[k*VEC_W +: VEC_W];
        assign b_slice[k] = b_in[k*VEC_W +: VEC_W];
    end

    // First set request bit searching ptr, ptr+1, ... modulo NREQ.
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NREQ)) begin
                cand = cand - (IDX_W+1)'(NREQ);
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= StIdle;
            ptr               <= '0;
            owner             <= '0;
            timer             <= '0;
            grant             <= '0;
            done              <= '0;
            err               <= '0;
            result            <= '0;
            busy              <= 1'b0;
            vector_a          <= '0;
            vector_b          <= '0;
            start_dot_product <= 1'b0;
            rstn_dot          <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                StIdle: begin
                    if (win_found) begin
                        owner    <= win_idx;
                        grant    <= ONE_HOT0 << win_idx;
                        vector_a <= a_slice[win_idx];
                        vector_b <= b_slice[win_idx];
                        rstn_dot <= 1'b1;
                        busy     <= 1'b1;
                        state    <= StLoad;
                    end
                end
                // Engine has been out of reset for one cycle before start rises.
                StLoad: begin
                    start_dot_product <= 1'b1;
                    timer             <= '0;
                    state             <= StWait;
                end
                StWait: begin
                    if (dot_product_done) begin
                        result            <= dot_product_result;
                        done              <= grant;
                        start_dot_product <= 1'b0;
                        rstn_dot          <= 1'b0;
                        state             <= StResp;
                    end else if (timer == TMR_W'(TIMEOUT)) begin
                        err               <= grant;
                        start_dot_product <= 1'b0;
                        rstn_dot          <= 1'b0;
                        state             <= StResp;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StResp: begin
                    ptr   <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
